clk_switch_2to1: RTL and testbench
==================================

Name: clk_switch_2to1

Overview:
- Glitch-free 2-to-1 clock multiplexer.
- Selects between two asynchronous source clocks, io_clkin_0 and io_clkin_1, under control of a select level. Produces io_clko with no runt pulses during a switch.
- Sits at the clock-generation boundary, ahead of downstream clock trees.
- Each source is disabled, then the other enabled, through per-domain synchronizers with mutual-exclusion interlock.

Parameters:
- SYNC_STAGES, 2, number of rising-edge synchronizer flops per source domain (minimum 2).
- RST_SEL, 0, source whose enable path is released first after reset when io_clksel matches it (informational; behaviour below is defined for io_clksel).

Ports:
- clock  input  1  system clock port. Interface uniformity only; no functional logic is clocked by it.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- io_clkin_0  input  1  source clock 0.
- io_clkin_1  input  1  source clock 1. Asynchronous to clkin_0; any frequency ratio.
- io_clksel  input  1  0 selects clkin_0, 1 selects clkin_1. May change asynchronously.
- io_clko  output  1  switched clock.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Per domain i (i = 0, 1):
  - Request: req0 = ~io_clksel & ~en1; req1 = io_clksel & ~en0.
  - req_i passes through SYNC_STAGES flops clocked on the rising edge of io_clkin_i.
  - Synchronizer output is captured on the falling edge of io_clkin_i into en_i.
- Output: io_clko = (io_clkin_0 & en0) | (io_clkin_1 & en1). This is the only combinational gate on the clock path; en_i changes only while io_clkin_i is low.
- Reset (reset=0):
  - All synchronizer flops and en0/en1 cleared asynchronously; io_clko = 0 immediately.
  - Never X/Z.
- After reset release with io_clksel = 0:
  - en0 sets after SYNC_STAGES rising edges plus one falling edge of clkin_0.
  - io_clko then follows clkin_0 starting at its next rising edge.
  - The same applies symmetrically for io_clksel = 1 with clkin_1.
- Switch 0->1:
  - en0 clears after SYNC_STAGES rising edges plus one falling edge of clkin_0.
  - en1 then sets after SYNC_STAGES rising edges plus one falling edge of clkin_1.
  - io_clko is held low in the gap.
- Switch 1->0: symmetric.
- Invariants:
  - en0 & en1 never both 1.
  - io_clko high pulse width is never shorter than the high phase of the currently enabled source.
  - io_clko low time is never shorter than the low phase of the source being disabled.
- Select toggles back before the old enable drops: the old source stays enabled with no output disturbance.
- Select pulse shorter than SYNC_STAGES source edges: either ignored or it completes a full switch. A partial pulse is never allowed.
- Stopped source clock: switching away from it hangs with io_clko low. This is documented, not handled.
- Reset asserted mid-switch: io_clko forced to 0 asynchronously; after release the normal start-up sequence runs.
- io_clko is never X/Z while reset=1 and both sources toggle with io_clksel known.

Test Plan:
- Reset 1000 ns, clkin_0 period 14 ns, clkin_1 period 4.6 ns, sel=0 -> io_clko=0 during reset. After release, io_clko matches clkin_0 within 3 clkin_0 cycles; en1 stays 0.
- sel 0->1 at an arbitrary time -> io_clko low for one to three clkin_0 periods and some clkin_1 periods. Then io_clko tracks clkin_1; no high pulse below 2.3 ns, no low pulse below 7 ns at the 0-side cutoff.
- sel 1->0 -> io_clko reverts to clkin_0; no high pulse shorter than 7 ns; en0 & en1 never both 1 (assertion).
- Drive sel from a counter bit toggling every 64 clkin_0 cycles for 768 cycles -> every switch completes; io_clko never X/Z (continuous check).
- sel pulse of 1 clkin_0 period -> either no switch or one clean full switch; pulse-width checker passes.
- Assert reset mid-switch -> io_clko = 0 within zero clock edges. After release it comes up on the source named by sel.

Source files
------------

// File: rtl/clk_switch_2to1.sv
// Glitch-free 2-to-1 clock multiplexer. Each source has its own enable,
// and an enable may only rise once the other source's enable has dropped.
`timescale 1ns/1ps

module clk_switch_2to1 #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_SEL     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic io_clkin_0,
  input  logic io_clkin_1,
  input  logic io_clksel,
  output logic io_clko
);

  logic                   req0;
  logic                   req1;
  logic [SYNC_STAGES-1:0] sync0;
  logic [SYNC_STAGES-1:0] sync1;
  logic                   en0;
  logic                   en1;

  // The port clock and RST_SEL carry no function; they are tied off here.
  logic unused_cfg;
  assign unused_cfg = clock ^ RST_SEL;

  // Interlock: a source may request its enable only while the other is off.
  assign req0 = ~io_clksel & ~en1;
  assign req1 =  io_clksel & ~en0;

  always_ff @(posedge io_clkin_0 or negedge reset) begin
    if (!reset) begin
      sync0 <= '0;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], req0};
    end
  end

  // Enables move on the falling edge, so they only change while their
  // own source is low and can never clip a high phase.
  always_ff @(negedge io_clkin_0 or negedge reset) begin
    if (!reset) begin
      en0 <= 1'b0;
    end else begin
      en0 <= sync0[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge io_clkin_1 or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
    end else begin
      sync1 <= {sync1[SYNC_STAGES-2:0], req1};
    end
  end

  always_ff @(negedge io_clkin_1 or negedge reset) begin
    if (!reset) begin
      en1 <= 1'b0;
    end else begin
      en1 <= sync1[SYNC_STAGES-1];
    end
  end

  assign io_clko = (io_clkin_0 & en0) | (io_clkin_1 & en1);

endmodule

// File: tb/tb_clk_switch_2to1.sv
// Bench for clk_switch_2to1: settled-output reference model, pulse-width
// and mutual-exclusion monitors, and a directed/randomized select sequence.
`timescale 1ns/1ps

module tb_clk_switch_2to1;

  localparam realtime SETTLE = 120.0;

  logic clock;
  logic reset;
  logic io_clkin_0;
  logic io_clkin_1;
  logic io_clksel;
  logic io_clko;

  int n_cmp = 0;
  int n_bad = 0;

  realtime last_change = 0.0;
  realtime last_edge   = 0.0;
  realtime gap_max     = 0.0;
  bit      edge_valid  = 1'b0;
  int      hi_src      = 0;

  clk_switch_2to1 #(.SYNC_STAGES(2), .RST_SEL(1'b0)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_clkin_0 (io_clkin_0),
    .io_clkin_1 (io_clkin_1),
    .io_clksel  (io_clksel),
    .io_clko    (io_clko)
  );

  // Clock/reset block: edge grids never coincide (clkin_1 offset by 13 ps).
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    io_clkin_0 = 1'b0;
    forever #7 io_clkin_0 = ~io_clkin_0;
  end

  initial begin
    io_clkin_1 = 1'b0;
    #0.013;
    forever #2.3 io_clkin_1 = ~io_clkin_1;
  end

  initial begin
    #60us;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $realtime);
    end
  endtask

  task automatic check_min(input string tag, input realtime obs, input realtime lim);
    n_cmp++;
    assert (obs >= lim) else begin
      n_bad++;
      $error("FAIL %s observed=%0.3f expected>=%0.3f at %0t", tag, obs, lim, $realtime);
    end
  endtask

  // Reference model: once select and reset have been quiet for SETTLE,
  // the output equals the selected source; in reset it is 0.
  always @(io_clksel or posedge reset) last_change = $realtime;

  always @(posedge io_clkin_0) begin
    #3.051;
    if (reset === 1'b0)
      check("rst_low", io_clko, 1'b0);
    else if ($realtime - last_change >= SETTLE)
      check("model_follow", io_clko, io_clksel ? io_clkin_1 : io_clkin_0);
  end

  always @(dut.en0 or dut.en1) begin
    if (reset === 1'b1) check("en_mutex", dut.en0 & dut.en1, 1'b0);
  end

  // Pulse-width monitor; the source of a high pulse is identified from
  // the edge time (clkin_0 edges lie on a 7 ns grid, clkin_1 never does).
  always @(io_clko) begin
    if (reset !== 1'b1) begin
      edge_valid = 1'b0;
    end else begin
      check("clko_known", $isunknown(io_clko), 1'b0);
      if (!$isunknown(io_clko)) begin
        realtime t;
        int      tps;
        t   = $realtime;
        tps = $rtoi(t * 1000.0 + 0.5);
        if (io_clko) begin
          if (edge_valid) begin
            if (t - last_edge > gap_max) gap_max = t - last_edge;
            check_min("low_width", t - last_edge, 2.29);
          end
          hi_src = (tps % 7000 == 0) ? 0 : 1;
        end else if (edge_valid) begin
          check_min("high_width", t - last_edge, (hi_src == 0) ? 6.99 : 2.29);
        end
        last_edge  = t;
        edge_valid = 1'b1;
      end
    end
  end

  task automatic check_follow(input logic s);
    for (int k = 0; k < 3; k++) begin
      if (s == 1'b0) begin
        @(posedge io_clkin_0); #3.451;
        check("follow_hi0", io_clko, 1'b1);
        @(negedge io_clkin_0); #3.451;
        check("follow_lo0", io_clko, 1'b0);
      end else begin
        @(posedge io_clkin_1); #1.151;
        check("follow_hi1", io_clko, 1'b1);
        @(negedge io_clkin_1); #1.151;
        check("follow_lo1", io_clko, 1'b0);
      end
    end
    check("en_selected", s ? dut.en1 : dut.en0, 1'b1);
    check("en_other", s ? dut.en0 : dut.en1, 1'b0);
  endtask

  initial begin
    logic prev;
    reset     = 1'b0;
    io_clksel = 1'b0;

    // Reset phase.
    #500;
    check("reset_clko", io_clko, 1'b0);
    check("reset_en0", dut.en0, 1'b0);
    check("reset_en1", dut.en1, 1'b0);
    #500.001;
    reset = 1'b1;

    // Start-up on clkin_0 within 3 cycles.
    repeat (3) @(posedge io_clkin_0);
    check_follow(1'b0);

    // Randomized switches at arbitrary phases.
    repeat (4) begin
      repeat ($urandom_range(5, 40)) @(posedge io_clkin_0);
      #(1.051 + $urandom_range(0, 5));
      prev      = io_clksel;
      gap_max   = 0.0;
      io_clksel = ~io_clksel;
      #150;
      check_follow(io_clksel);
      if (prev == 1'b0) check_min("cutoff_gap", gap_max, 6.99);
    end

    // Counter-driven select: bit 6 toggles every 64 clkin_0 cycles.
    for (int c = 0; c < 768; c++) begin
      @(posedge io_clkin_0); #1.051;
      io_clksel = c[6];
    end
    #SETTLE;
    check_follow(io_clksel);

    // One-period select pulse: ignored or a full round trip, ending on 0.
    io_clksel = 1'b0;
    #200;
    @(posedge io_clkin_0); #1.051;
    io_clksel = 1'b1;
    @(posedge io_clkin_0); #1.051;
    io_clksel = 1'b0;
    #200;
    check_follow(1'b0);

    // Reset asserted in the middle of a 0->1 switch.
    io_clksel = 1'b1;
    repeat (3) @(posedge io_clkin_1);
    #1.151;
    reset = 1'b0;
    #0.001;
    check("midrst_clko", io_clko, 1'b0);
    check("midrst_en0", dut.en0, 1'b0);
    check("midrst_en1", dut.en1, 1'b0);
    #100;
    reset = 1'b1;
    #SETTLE;
    check_follow(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
